// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types.
//   REG_AW      : architectural register address width
//   DW_DEFAULT  : default datapath width
//   reg_addr_t  : architectural register index
//   ZERO_REG_EN : register 0 is hardwired to zero (decode relies on this)
package cpu_pkg;

    localparam int REG_AW      = 5;
    localparam int DW_DEFAULT  = 32;
    localparam bit ZERO_REG_EN = 1'b1;

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rf_read_bypass.sv
// One register-file read port: write-through bypass, zero-register forcing
// and busy-bit bypass for the addressed register.
// Ports:
//   rdAddr              : read address
//   storedData/Busy     : registered value and busy bit at rdAddr
//   wr0*/wr1*           : same-cycle write ports (wr1 has priority)
//   rsvEn/rsvAddr       : same-cycle reserve request
//   rdData/rdBusy       : bypassed read data and busy flag
module rf_read_bypass #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rdAddr,
    input  logic [DW-1:0] storedData,
    input  logic          storedBusy,
    input  logic          wr0En,
    input  logic [AW-1:0] wr0Addr,
    input  logic [DW-1:0] wr0Data,
    input  logic          wr1En,
    input  logic [AW-1:0] wr1Addr,
    input  logic [DW-1:0] wr1Data,
    input  logic          rsvEn,
    input  logic [AW-1:0] rsvAddr,
    output logic [DW-1:0] rdData,
    output logic          rdBusy
);

    logic wr0Hit;
    logic wr1Hit;
    logic rsvHit;
    logic isZero;

    assign wr0Hit = wr0En && (wr0Addr == rdAddr);
    assign wr1Hit = wr1En && (wr1Addr == rdAddr);
    assign rsvHit = rsvEn && (rsvAddr == rdAddr);
    assign isZero = (ZERO_REG != 0) && (rdAddr == '0);

    always_comb begin
        rdData = storedData;
        rdBusy = storedBusy;
        if (wr1Hit) begin
            rdData = wr1Data;
        end else if (wr0Hit) begin
            rdData = wr0Data;
        end
        // A writeback frees the register for decode this cycle, unless a
        // newer producer reserves it in the same cycle.
        if ((wr0Hit || wr1Hit) && !rsvHit) begin
            rdBusy = 1'b0;
        end
        if (isZero) begin
            rdData = '0;
            rdBusy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_multiport_sb.sv
// Multi-read, dual-write register file with per-register busy scoreboard.
// Ports:
//   clk, rst          : clock, async active-low reset
//   rd_addr/rd_data   : NR packed read ports (combinational, bypassed)
//   rd_busy           : scoreboard busy bit per read port (bypassed)
//   wr0_*/wr1_*       : write ports, wr1 wins on same-address conflict
//   rsv_en/rsv_addr   : reserve a register at issue
//   busy_cnt          : registered count of busy registers
module regfile_multiport_sb
    import cpu_pkg::*;
#(
    parameter int DW       = DW_DEFAULT,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]   rd_busy,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_addr,
    input  logic [DW-1:0]   wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_addr,
    input  logic [DW-1:0]   wr1_data,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    output logic [AW:0]     busy_cnt
);

    logic [DW-1:0]    regFile [DEPTH];
    logic [DW-1:0]    regNext [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic [AW:0]      cntNext;

    // While reset is held the request inputs are masked so reads show the
    // zeroed storage rather than bypassed write data.
    logic wr0Live;
    logic wr1Live;
    logic rsvLive;

    assign wr0Live = wr0_en && rst;
    assign wr1Live = wr1_en && rst;
    assign rsvLive = rsv_en && rst;

    always_comb begin
        busyNext = busy;
        cntNext  = '0;
        for (int r = 0; r < DEPTH; r++) begin
            regNext[r] = regFile[r];
            if (!((ZERO_REG != 0) && (r == 0))) begin
                if (wr1Live && (wr1_addr == AW'(r))) begin
                    regNext[r] = wr1_data;
                end else if (wr0Live && (wr0_addr == AW'(r))) begin
                    regNext[r] = wr0_data;
                end
                if (rsvLive && (rsv_addr == AW'(r))) begin
                    busyNext[r] = 1'b1;
                end else if ((wr1Live && (wr1_addr == AW'(r))) ||
                             (wr0Live && (wr0_addr == AW'(r)))) begin
                    busyNext[r] = 1'b0;
                end
            end
            cntNext = cntNext + (AW+1)'(busyNext[r]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regFile[r] <= '0;
            end
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regFile[r] <= regNext[r];
            end
            busy     <= busyNext;
            busy_cnt <= cntNext;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : gRead
        rf_read_bypass #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) uBypass (
            .rdAddr     (rd_addr[k*AW +: AW]),
            .storedData (regFile[rd_addr[k*AW +: AW]]),
            .storedBusy (busy[rd_addr[k*AW +: AW]]),
            .wr0En      (wr0Live),
            .wr0Addr    (wr0_addr),
            .wr0Data    (wr0_data),
            .wr1En      (wr1Live),
            .wr1Addr    (wr1_addr),
            .wr1Data    (wr1_data),
            .rsvEn      (rsvLive),
            .rsvAddr    (rsv_addr),
            .rdData     (rd_data[k*DW +: DW]),
            .rdBusy     (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Self-checking bench for regfile_multiport_sb against an array-based model.
module tb_regfile_multiport_sb;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            wr0_en = 1'b0;
    reg_addr_t       wr0_addr = '0;
    logic [DW-1:0]   wr0_data = '0;
    logic            wr1_en = 1'b0;
    reg_addr_t       wr1_addr = '0;
    logic [DW-1:0]   wr1_data = '0;
    logic            rsv_en = 1'b0;
    reg_addr_t       rsv_addr = '0;
    logic [AW:0]     busy_cnt;

    regfile_multiport_sb #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .ZERO_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    logic [DW-1:0] mMem  [DEPTH];
    bit            mBusy [DEPTH];
    logic [DW-1:0] obsData [NR];
    logic          obsBusy [NR];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i]  = '0;
            mBusy[i] = 1'b0;
        end
    endfunction

    function automatic int modelCount();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(mBusy[i]);
        return c;
    endfunction

    // Expected combinational read given the current inputs.
    function automatic logic [DW-1:0] expData(input reg_addr_t a);
        if (a == 0) return '0;
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
        return mMem[a];
    endfunction

    function automatic logic expBusy(input reg_addr_t a);
        bit written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        bit reserved = rsv_en && rsv_addr == a;
        if (a == 0) return 1'b0;
        if (written && !reserved) return 1'b0;
        return mBusy[a];
    endfunction

    // Writes apply in port order so the later (wr1) one overwrites; the
    // reserve is applied last so it overrides any clear.
    function automatic void modelCommit();
        if (wr0_en && wr0_addr != 0) begin
            mMem[wr0_addr]  = wr0_data;
            mBusy[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 0) begin
            mMem[wr1_addr]  = wr1_data;
            mBusy[wr1_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) mBusy[rsv_addr] = 1'b1;
    endfunction

    task automatic checkReads();
        reg_addr_t a;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            obsData[k] = rd_data[k*DW +: DW];
            obsBusy[k] = rd_busy[k];
            chk($sformatf("rd_data[%0d] a=%0d", k, a), obsData[k], expData(a));
            chk($sformatf("rd_busy[%0d] a=%0d", k, a), obsBusy[k], expBusy(a));
        end
    endtask

    task automatic doCycle(input logic e0, input reg_addr_t a0, input logic [DW-1:0] d0,
                           input logic e1, input reg_addr_t a1, input logic [DW-1:0] d1,
                           input logic re, input reg_addr_t ra,
                           input reg_addr_t r0, input reg_addr_t r1);
        @(negedge clk);
        wr0_en = e0; wr0_addr = a0; wr0_data = d0;
        wr1_en = e1; wr1_addr = a1; wr1_data = d1;
        rsv_en = re; rsv_addr = ra;
        rd_addr = {r1, r0};
        #1;
        checkReads();
        @(posedge clk);
        modelCommit();
        #1;
        chk("busy_cnt", busy_cnt, modelCount());
    endtask

    task automatic idle(input reg_addr_t r0, input reg_addr_t r1);
        doCycle(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic randomInputs();
        wr0_en = 1'($urandom); wr0_addr = AW'($urandom); wr0_data = $urandom;
        wr1_en = 1'($urandom); wr1_addr = AW'($urandom); wr1_data = $urandom;
        rsv_en = 1'($urandom); rsv_addr = AW'($urandom);
        rd_addr = NR*AW'($urandom);
    endtask

    int cntBefore;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, nChecks=%0d", nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        // Reset held with random inputs: everything reads zero.
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            randomInputs();
            #1;
            chk("reset rd_data", rd_data, '0);
            chk("reset rd_busy", rd_busy, '0);
            chk("reset busy_cnt", busy_cnt, '0);
        end
        @(negedge clk);
        wr0_en = 0; wr1_en = 0; rsv_en = 0;
        rst = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) idle(reg_addr_t'(2*i), reg_addr_t'(2*i + 1));

        // Write with same-cycle bypass, then readback.
        doCycle(1, 10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 10, 0);
        chk("bypass wr0 reg10", obsData[0], 32'hDEADBEEF);
        idle(10, 0);
        chk("stored reg10", obsData[0], 32'hDEADBEEF);

        // Dual-write conflict and independent dual write.
        doCycle(1, 5, 32'h11, 1, 5, 32'h22, 0, 0, 5, 5);
        chk("conflict bypass p0", obsData[0], 32'h22);
        chk("conflict bypass p1", obsData[1], 32'h22);
        doCycle(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 5, 3);
        chk("conflict stored", obsData[0], 32'h22);
        idle(3, 4);
        chk("dual wr0 reg3", obsData[0], 32'hA);
        chk("dual wr1 reg4", obsData[1], 32'hB);

        // Zero register ignores writes and reserves.
        cntBefore = int'(busy_cnt);
        doCycle(1, 0, 32'h1234, 0, 0, 0, 1, 0, 0, 0);
        chk("zero bypass", obsData[0], 0);
        chk("zero busy", obsBusy[0], 0);
        idle(0, 0);
        chk("zero stored", obsData[0], 0);
        chk("zero busy_cnt", busy_cnt, cntBefore);

        // Scoreboard reserve / clear / reserve-wins.
        doCycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
        chk("rsv same-cycle busy", obsBusy[0], 0);
        idle(7, 0);
        chk("rsv busy next", obsBusy[0], 1);
        chk("rsv busy_cnt", busy_cnt, 1);
        doCycle(1, 7, 32'h77, 0, 0, 0, 0, 0, 7, 0);
        chk("wb busy bypass", obsBusy[0], 0);
        chk("wb busy_cnt", busy_cnt, 0);
        doCycle(0, 0, 0, 1, 7, 32'h78, 1, 7, 7, 0);
        chk("rsv+wb busy", obsBusy[0], 0);
        chk("rsv+wb busy_cnt", busy_cnt, 1);
        idle(7, 0);
        chk("rsv+wb held busy", obsBusy[0], 1);
        chk("rsv+wb data", obsData[0], 32'h78);

        // Randomized traffic with frequent address collisions.
        for (int i = 0; i < 400; i++) begin
            reg_addr_t a0 = reg_addr_t'($urandom);
            reg_addr_t a1 = ($urandom_range(0, 3) == 0) ? a0 : reg_addr_t'($urandom);
            reg_addr_t ra = ($urandom_range(0, 3) == 0) ? a0 : reg_addr_t'($urandom);
            reg_addr_t r0 = ($urandom_range(0, 2) == 0) ? a1 : reg_addr_t'($urandom);
            doCycle(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
                    1'($urandom), ra, r0, reg_addr_t'($urandom));
        end

        // Stress: reserve every register, then reset mid-sequence.
        for (int i = 1; i < DEPTH; i++) begin
            doCycle(1, reg_addr_t'(i), 32'h1000 + i, 0, 0, 0, 1, reg_addr_t'(i),
                    reg_addr_t'(i), 0);
        end
        chk("all reserved busy_cnt", busy_cnt, DEPTH - 1);
        @(negedge clk);
        randomInputs();
        #2 rst = 1'b0;
        modelReset();
        #1;
        chk("mid reset busy_cnt", busy_cnt, 0);
        chk("mid reset rd_data", rd_data, '0);
        chk("mid reset rd_busy", rd_busy, '0);
        @(negedge clk);
        wr0_en = 0; wr1_en = 0; rsv_en = 0;
        rst = 1'b1;
        for (int i = 0; i < DEPTH / 2; i++) idle(reg_addr_t'(2*i), reg_addr_t'(2*i + 1));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
